muldiv_seq: RTL
===============

Name: muldiv_seq

Overview:
- Iterative multi-cycle multiply/divide unit.
- Takes MUL and DIV out of the single-cycle ALU critical path.
- Sits beside the combinational ALU in EX: the decoder steers ALUOP_MUL/ALUOP_DIV here, and the pipeline stalls on in_ready/out_valid.
- Shift-add multiply and restoring divide, one bit per cycle, with a valid/ready handshake on both sides.

Parameters:
- WIDTH, 32, operand/result width; iteration count equals WIDTH.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  request present
- in_ready  output  1  unit can accept a request
- aluop  input  5  operation code (ALUOP_MUL, ALUOP_DIV; other codes are unsupported)
- val1  input  WIDTH  multiplicand / dividend
- val2  input  WIDTH  multiplier / divisor
- flush  input  1  abort current operation
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result
- result  output  WIDTH  product low half / quotient
- busy  output  1  state != IDLE

Behaviour:
- Reset (async, rst=1): state=IDLE, count=0, result=0, out_valid=0, busy=0; in_ready=1 after release. Reset mid-operation discards all work.
- States: IDLE, BUSY, DONE.
- in_ready = (state==IDLE), decoded from state only. A request is accepted only in IDLE.
- Handshake at cycle T (in_valid & in_ready):
  - val1/val2 are latched into the operand registers and the op is latched.
  - If op==ALUOP_MUL: acc=0, count=0, next state BUSY.
  - If op==ALUOP_DIV and val2==0: result=all-ones, next state DONE. out_valid=1 at T+1.
  - If any other op: result=0, next state DONE. out_valid=1 at T+1.
  - Otherwise DIV: remainder=0, quotient reg=val1, count=0, next state BUSY.
- BUSY MUL step: if multiplier LSB=1, acc += multiplicand. Then multiplicand <<=1 and multiplier >>=1.
  - All arithmetic is modulo 2^WIDTH; only the low WIDTH bits are kept (same as val1*val2 truncated).
- BUSY DIV step (restoring):
  - {rem,quo} <<= 1.
  - If rem >= divisor: rem -= divisor and quo[0]=1.
  - All values are unsigned.
- count increments once per BUSY cycle. At the step where count==WIDTH-1, the final value is written to result and the next state is DONE.
- Latency: BUSY occupies cycles T+1..T+WIDTH. out_valid rises at T+WIDTH+1 (T+33 at default).
- DONE:
  - out_valid=1; result and out_valid are held stable while out_ready=0.
  - With out_ready=1: next state IDLE, out_valid=0 the following cycle, result retains its value.
- Back-to-back: a new request is accepted at the earliest in the first IDLE cycle after the DONE handshake.
- flush=1 in any state forces IDLE next cycle and clears out_valid, so no result is delivered. flush overrides a simultaneous in_valid in IDLE (request not accepted) and a simultaneous out_ready in DONE.
- in_valid while not IDLE is ignored; the inputs are not required to stay stable after acceptance.
- busy=1 in BUSY and DONE.

Decomposition:
- ALUOP_MUL/ALUOP_DIV codes come from the shared defines header (same codes as the single-cycle ALU).
- Add to that header: MULDIV state encodings (IDLE=2'd0, BUSY=2'd1, DONE=2'd2) and the divide-by-zero result constant (all-ones).
- One natural sub-module: muldiv_step, the combinational single-iteration datapath. Inputs: op, acc/rem, operand regs. Outputs: next values.
- The FSM, counter and handshake stay in muldiv_seq.

Test Plan:
- MUL: val1=7, val2=6, accepted at T -> out_valid=1 at T+33, result=42; in_ready=0 from T+1 until IDLE.
- MUL overflow: val1=0xFFFFFFFF, val2=2 -> result=0xFFFFFFFE. Also 0x10000*0x10000 -> result=0.
- DIV: val1=100, val2=7 -> result=14 at T+33. Also val1=0xFFFFFFFF, val2=1 -> 0xFFFFFFFF; val1=5, val2=9 -> 0.
- DIV by zero: val1=123, val2=0 -> out_valid at T+1, result=0xFFFFFFFF. Unsupported op (e.g. ADD code) -> out_valid at T+1, result=0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> result/out_valid stable and in_ready=0. Raise out_ready -> IDLE next cycle; the next request is accepted one cycle after.
- Abort: flush at T+10 of a DIV -> IDLE at T+11, no out_valid. Repeat with rst pulsed asynchronously mid-BUSY -> immediate IDLE, result=0; a following MUL 3*5 returns 15.

Source files
------------

// File: rtl/muldiv_seq_pkg.sv
// Shared ALU opcode and multiply/divide unit definitions.
package muldiv_seq_pkg;

    // ALU opcode width and codes, shared with the single-cycle ALU decoder
    localparam int ALUOP_W = 5;
    localparam logic [ALUOP_W-1:0] ALUOP_ADD = 5'd0;
    localparam logic [ALUOP_W-1:0] ALUOP_SUB = 5'd1;
    localparam logic [ALUOP_W-1:0] ALUOP_MUL = 5'd10;
    localparam logic [ALUOP_W-1:0] ALUOP_DIV = 5'd11;

    // Multiply/divide sequencer states
    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    // Divide-by-zero result is all-ones; replicate this bit across the result width
    localparam logic MULDIV_DIV0_FILL = 1'b1;

endpackage

// File: rtl/muldiv_seq_if.sv
// Request/response bus between the EX stage and the multiply/divide unit.
interface muldiv_seq_if #(
    parameter int WIDTH = 32
);
    import muldiv_seq_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [ALUOP_W-1:0] aluop;
    logic [WIDTH-1:0]   val1;
    logic [WIDTH-1:0]   val2;
    logic               flush;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   result;
    logic               busy;

    // Pipeline side issues requests and consumes results
    modport master (
        output in_valid, aluop, val1, val2, flush, out_ready,
        input  in_ready, out_valid, result, busy
    );

    // Multiply/divide unit side
    modport slave (
        input  in_valid, aluop, val1, val2, flush, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply or restoring divide (combinational).
module muldiv_step
    import muldiv_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             i_is_div,
    input  logic [WIDTH-1:0] i_acc,    // product accumulator / partial remainder
    input  logic [WIDTH-1:0] i_a,      // multiplicand / divisor
    input  logic [WIDTH-1:0] i_b,      // multiplier / quotient-dividend shift reg
    output logic [WIDTH-1:0] o_acc,
    output logic [WIDTH-1:0] o_a,
    output logic [WIDTH-1:0] o_b
);
    logic [WIDTH:0] w_rem_sh;
    logic [WIDTH:0] w_diff;

    // Remainder gets one extra bit so the compare sees the bit shifted out of rem
    assign w_rem_sh = {i_acc, i_b[WIDTH-1]};
    assign w_diff   = w_rem_sh - {1'b0, i_a};

    // Select the next-state values for the active operation
    always_comb begin
        o_acc = i_acc;
        o_a   = i_a;
        o_b   = i_b;
        if (i_is_div) begin
            // Restoring step: keep the subtraction only when it does not borrow
            if (!w_diff[WIDTH]) begin
                o_acc = w_diff[WIDTH-1:0];
                o_b   = {i_b[WIDTH-2:0], 1'b1};
            end else begin
                o_acc = w_rem_sh[WIDTH-1:0];
                o_b   = {i_b[WIDTH-2:0], 1'b0};
            end
        end else begin
            if (i_b[0]) o_acc = i_acc + i_a;
            o_a = i_a << 1;
            o_b = i_b >> 1;
        end
    end
endmodule

// File: rtl/muldiv_seq.sv
// Iterative multiply/divide unit: one bit per cycle, valid/ready on both sides.
module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    muldiv_seq_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    md_state_e        r_state;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_is_div;
    logic [WIDTH-1:0] r_result;
    logic             r_out_valid;

    logic [WIDTH-1:0] w_acc_nxt;
    logic [WIDTH-1:0] w_a_nxt;
    logic [WIDTH-1:0] w_b_nxt;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .i_is_div (r_is_div),
        .i_acc    (r_acc),
        .i_a      (r_a),
        .i_b      (r_b),
        .o_acc    (w_acc_nxt),
        .o_a      (w_a_nxt),
        .o_b      (w_b_nxt)
    );

    assign bus.in_ready  = (r_state == MD_IDLE);
    assign bus.busy      = (r_state != MD_IDLE);
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;

    // Sequencer: accept, iterate WIDTH steps, hold result until consumed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= MD_IDLE;
            r_count     <= '0;
            r_acc       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_is_div    <= 1'b0;
            r_result    <= '0;
            r_out_valid <= 1'b0;
        end else if (bus.flush) begin
            // Abort wins over any handshake in the same cycle
            r_state     <= MD_IDLE;
            r_count     <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                MD_IDLE: begin
                    if (bus.in_valid) begin
                        r_a      <= bus.val1;
                        r_b      <= bus.val2;
                        r_acc    <= '0;
                        r_count  <= '0;
                        r_is_div <= (bus.aluop == ALUOP_DIV);
                        if (bus.aluop == ALUOP_MUL) begin
                            r_state <= MD_BUSY;
                        end else if (bus.aluop == ALUOP_DIV && bus.val2 == '0) begin
                            r_result    <= {WIDTH{MULDIV_DIV0_FILL}};
                            r_out_valid <= 1'b1;
                            r_state     <= MD_DONE;
                        end else if (bus.aluop == ALUOP_DIV) begin
                            // Divisor sits in the a register, dividend shifts out of b
                            r_a     <= bus.val2;
                            r_b     <= bus.val1;
                            r_state <= MD_BUSY;
                        end else begin
                            r_result    <= '0;
                            r_out_valid <= 1'b1;
                            r_state     <= MD_DONE;
                        end
                    end
                end
                MD_BUSY: begin
                    r_acc   <= w_acc_nxt;
                    r_a     <= w_a_nxt;
                    r_b     <= w_b_nxt;
                    r_count <= r_count + 1'b1;
                    if (r_count == CW'(WIDTH - 1)) begin
                        r_result    <= r_is_div ? w_b_nxt : w_acc_nxt;
                        r_out_valid <= 1'b1;
                        r_count     <= '0;
                        r_state     <= MD_DONE;
                    end
                end
                MD_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= MD_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= MD_IDLE;
                end
            endcase
        end
    end
endmodule
